// File: rtl/dsp_seq_pkg.sv
// Shared definitions for the MAC sequencer: the FSM state encoding and the
// depth of the token pipeline that mirrors the DSP slice's register stages.
package dsp_seq_pkg;

    // Input register, M (product) register, P (accumulator) register.
    localparam int STAGES = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/dsp_token_pipe.sv
// Token / clr-tag shift register that travels alongside the DSP datapath.
//   CLKR, RSTR : clock, asynchronous active-high reset
//   tok_in     : a sample pair was accepted this cycle
//   clr_in     : the accepted sample is the first of its job
//   tok, clr   : per-stage token valid and clr tag (index 0 = first stage)
module dsp_token_pipe #(
    parameter int STAGES = dsp_seq_pkg::STAGES
) (
    input  logic              CLKR,
    input  logic              RSTR,
    input  logic              tok_in,
    input  logic              clr_in,
    output logic [STAGES-1:0] tok,
    output logic [STAGES-1:0] clr
);

    logic [STAGES-1:0] tok_q, tok_d;
    logic [STAGES-1:0] clr_q, clr_d;

    // No backpressure: every stage advances every cycle. A clr tag is only
    // meaningful when attached to a real token.
    always_comb begin
        tok_d = {tok_q[STAGES-2:0], tok_in};
        clr_d = {clr_q[STAGES-2:0], clr_in & tok_in};
    end

    always_ff @(posedge CLKR or posedge RSTR) begin
        if (RSTR) begin
            tok_q <= '0;
            clr_q <= '0;
        end else begin
            tok_q <= tok_d;
            clr_q <= clr_d;
        end
    end

    assign tok = tok_q;
    assign clr = clr_q;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequencer that drives the clock enables and opmode of a pipelined DSP
// multiply-accumulate slice for one vector job of len sample pairs.
//   CLKR, RSTR        : clock, asynchronous active-high reset
//   start, len        : job request and its length (len=0 is rejected)
//   s_valid / s_ready : sample handshake; accept = s_valid & s_ready
//   CE_in, CE_m, CE_p : enables for input, M and P registers
//   opmode_clr        : P loads (1) or accumulates (0) when CE_p is high
//   busy, done        : job in progress / one-cycle result-valid pulse
//   err_start         : one-cycle pulse on a rejected start
module dsp_mac_sequencer #(
    parameter int LEN_W  = 8,
    parameter int STAGES = dsp_seq_pkg::STAGES
) (
    input  logic             CLKR,
    input  logic             RSTR,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             CE_in,
    output logic             CE_m,
    output logic             CE_p,
    output logic             opmode_clr,
    output logic             busy,
    output logic             done,
    output logic             err_start
);

    import dsp_seq_pkg::*;

    seq_state_e        state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              first_q, first_d;
    logic              accept;
    logic              err;
    logic [STAGES-1:0] tok;
    logic [STAGES-1:0] clr;

    assign s_ready = (state_q == ST_FEED);
    assign accept  = s_valid & s_ready;

    dsp_token_pipe #(.STAGES(STAGES)) u_pipe (
        .CLKR   (CLKR),
        .RSTR   (RSTR),
        .tok_in (accept),
        .clr_in (first_q),
        .tok    (tok),
        .clr    (clr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        err     = 1'b0;
        case (state_q)
            // DONE is a one-cycle state that accepts a new start like IDLE.
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (len != '0) begin
                        state_d = ST_FEED;
                        cnt_d   = len;
                        first_d = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            ST_FEED: begin
                err = start;
                if (accept) begin
                    cnt_d   = cnt_q - 1'b1;
                    first_d = 1'b0;
                    if (cnt_q == LEN_W'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                err = start;
                // No accepts happen in DRAIN, so a token at stage 1 with
                // stage 0 empty is the last one taking its CE_p.
                if (tok[1] && !tok[0]) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLKR or posedge RSTR) begin
        if (RSTR) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    assign CE_in      = accept;
    assign CE_m       = tok[0];
    assign CE_p       = tok[1];
    assign opmode_clr = clr[1];
    assign busy       = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    // Gated so a start seen while reset is held never produces a pulse.
    assign err_start  = err & ~RSTR;

    // Last-stage token and the off-stage clr tags have no consumer here.
    logic unused_tags;
    assign unused_tags = ^{tok[STAGES-1], clr[STAGES-1], clr[0]};

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
module tb_dsp_mac_sequencer;

    localparam int LEN_W = 8;

    logic             CLKR = 1'b0;
    logic             RSTR;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             s_valid;
    logic             s_ready, CE_in, CE_m, CE_p, opmode_clr, busy, done, err_start;

    dsp_mac_sequencer #(.LEN_W(LEN_W)) dut (
        .CLKR       (CLKR),
        .RSTR       (RSTR),
        .start      (start),
        .len        (len),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .CE_in      (CE_in),
        .CE_m       (CE_m),
        .CE_p       (CE_p),
        .opmode_clr (opmode_clr),
        .busy       (busy),
        .done       (done),
        .err_start  (err_start)
    );

    always #5 CLKR = ~CLKR;

    int cyc = 0;
    always @(posedge CLKR) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    typedef struct packed {
        int   cyc;
        logic clr;
    } pexp_t;

    pexp_t pq[$];   // expected CE_p cycle and opmode_clr
    int    mq[$];   // expected CE_m cycles
    int    dq[$];   // expected done cycles

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every CE_m / CE_p / done must match a pushed entry.
    always @(negedge CLKR) begin
        if (RSTR === 1'b0) begin
            if (CE_m === 1'b1) begin
                chk("ce_m_expected", int'(mq.size() != 0), 1);
                if (mq.size() != 0) chk("ce_m_cycle", cyc, mq.pop_front());
            end
            if (CE_p === 1'b1) begin
                chk("ce_p_expected", int'(pq.size() != 0), 1);
                if (pq.size() != 0) begin
                    pexp_t e;
                    e = pq.pop_front();
                    chk("ce_p_cycle", cyc, e.cyc);
                    chk("opmode_clr", opmode_clr, e.clr);
                end
            end
            if (done === 1'b1) begin
                chk("done_expected", int'(dq.size() != 0), 1);
                if (dq.size() != 0) chk("done_cycle", cyc, dq.pop_front());
            end
        end
    end

    // One clock cycle: check combinational outputs mid-cycle, push the
    // downstream events implied by an expected accept, then advance.
    task automatic step(input bit ce, input bit clr, input bit last,
                        input bit bz, input bit err);
        @(negedge CLKR);
        chk("ce_in", CE_in, ce);
        chk("busy", busy, bz);
        chk("err_start", err_start, err);
        if (ce) begin
            pq.push_back('{cyc: cyc + 2, clr: clr});
            mq.push_back(cyc + 1);
            if (last) dq.push_back(cyc + 3);
        end
        @(posedge CLKR);
        #1;
    endtask

    task automatic sb_empty(input string tag);
        chk(tag, pq.size() + mq.size() + dq.size(), 0);
    endtask

    initial begin
        RSTR = 1'b1; start = 1'b1; len = '0; s_valid = 1'b1;
        #2;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_ce_in", CE_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_start, 0);
        chk("rst_cnt", dut.cnt_q, 0);
        repeat (2) @(posedge CLKR);
        #1;
        RSTR = 1'b0; start = 1'b0; s_valid = 1'b0;

        // len=4, s_valid held high
        start = 1'b1; len = 8'd4; s_valid = 1'b1;
        step(0, 0, 0, 0, 0);
        start = 1'b0;
        for (int i = 0; i < 4; i++) step(1, i == 0, i == 3, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);              // DONE
        step(0, 0, 0, 0, 0);
        sb_empty("t1_sb_empty");

        // len=3 with gaps 1,0,0,1,1
        start = 1'b1; len = 8'd3; s_valid = 1'b0;
        step(0, 0, 0, 0, 0);
        start = 1'b0;
        s_valid = 1'b1; step(1, 1, 0, 1, 0);
        s_valid = 1'b0; step(0, 0, 0, 1, 0);
        chk("t2_cnt_gap1", dut.cnt_q, 2);
        step(0, 0, 0, 1, 0);
        chk("t2_cnt_gap2", dut.cnt_q, 2);
        s_valid = 1'b1; step(1, 0, 0, 1, 0);
        step(1, 0, 1, 1, 0);
        s_valid = 1'b0;
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        sb_empty("t2_sb_empty");

        // len=0 rejected
        start = 1'b1; len = 8'd0; s_valid = 1'b1;
        step(0, 0, 0, 0, 1);
        start = 1'b0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        sb_empty("t3_sb_empty");

        // len=5 with starts during FEED and DRAIN
        start = 1'b1; len = 8'd5; s_valid = 1'b1;
        step(0, 0, 0, 0, 0);
        start = 1'b0;
        step(1, 1, 0, 1, 0);
        start = 1'b1; len = 8'd3;
        step(1, 0, 0, 1, 1);
        start = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 0, i == 2, 1, 0);
        start = 1'b1; len = 8'd2;
        step(0, 0, 0, 1, 1);
        start = 1'b0;
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        sb_empty("t4_sb_empty");

        // reset mid-DRAIN, then a fresh len=2 job
        start = 1'b1; len = 8'd2; s_valid = 1'b1;
        step(0, 0, 0, 0, 0);
        start = 1'b0;
        step(1, 1, 0, 1, 0);
        step(1, 0, 1, 1, 0);
        RSTR = 1'b1; start = 1'b1; len = 8'd0;
        #1;
        chk("r_busy", busy, 0);
        chk("r_ce_m", CE_m, 0);
        chk("r_ce_p", CE_p, 0);
        chk("r_done", done, 0);
        chk("r_s_ready", s_ready, 0);
        chk("r_err", err_start, 0);
        pq.delete(); mq.delete(); dq.delete();
        repeat (2) @(posedge CLKR);
        #1;
        RSTR = 1'b0; start = 1'b0; s_valid = 1'b0;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        start = 1'b1; len = 8'd2; s_valid = 1'b1;
        step(0, 0, 0, 0, 0);
        start = 1'b0;
        step(1, 1, 0, 1, 0);
        step(1, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        sb_empty("t5_sb_empty");

        // back-to-back len=1 jobs, second start in DONE
        start = 1'b1; len = 8'd1; s_valid = 1'b1;
        step(0, 0, 0, 0, 0);
        start = 1'b0;
        step(1, 1, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        start = 1'b1; len = 8'd1;
        step(0, 0, 0, 0, 0);              // DONE, start accepted
        start = 1'b0;
        step(1, 1, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        sb_empty("t6_sb_empty");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
